// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC width/reset defaults and next-PC source encoding.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES       = 4;

  // Next-PC source; decode uses the same encoding.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RET
  } src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the control path (master) and the PC sequencer (slave).
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned RAS_DEPTH = 4
);

  logic                         stall;
  logic                         branch_taken;
  logic [15:0]                  branch_offset;
  logic                         jump;
  logic [25:0]                  jump_target;
  logic                         jump_reg;
  logic [XLEN-1:0]              reg_target;
  logic                         link;
  logic                         ret;
  logic [XLEN-1:0]              pc;
  logic [XLEN-1:0]              pc_plus4;
  logic                         redirect;
  logic                         misalign;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_empty;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_target, jump_reg, reg_target,
           link, ret,
    input  pc, pc_plus4, redirect, misalign, ras_count, ras_empty
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_target, jump_reg, reg_target,
           link, ret,
    output pc, pc_plus4, redirect, misalign, ras_count, ras_empty
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d, wr_idx, top_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  // sp_q points at the next free slot; the top lives one below it.
  assign top_idx = sp_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    sp_d    = sp_q;
    count_d = count_q;
    wr_idx  = sp_q;
    if (push && do_pop) begin
      wr_idx = top_idx;
    end else if (push) begin
      sp_d = sp_q + PW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end else if (do_pop) begin
      sp_d    = top_idx;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with prioritised next-PC selection and a return-address stack.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  logic [XLEN-1:0]              pc_q, pc_d, pc_plus4, br_target, j_target, jr_raw, ras_top;
  logic                         redirect_q, redirect_d, misalign_q, misalign_d;
  logic                         ras_push, ras_pop, ras_empty;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  src_e                         src;

  assign pc_plus4  = pc_q + XLEN'(INSTR_BYTES);
  assign br_target = pc_plus4 + {{(XLEN-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign j_target  = {pc_plus4[XLEN-1:28], bus.jump_target, 2'b00};
  assign ras_empty = (ras_count == '0);

  // A stalled cycle must leave the RAS untouched as well as the PC.
  assign ras_push = !rst && !bus.stall && bus.link && (bus.jump || bus.jump_reg);
  assign ras_pop  = !rst && !bus.stall && bus.jump_reg && bus.ret;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus4),
    .top   (ras_top),
    .count (ras_count)
  );

  always_comb begin
    src = SRC_SEQ;
    if (bus.jump_reg)          src = (bus.ret && !ras_empty) ? SRC_RET : SRC_JR;
    else if (bus.jump)         src = SRC_J;
    else if (bus.branch_taken) src = SRC_BR;
  end

  always_comb begin
    jr_raw = (src == SRC_RET) ? ras_top : bus.reg_target;
    case (src)
      SRC_BR:          pc_d = br_target;
      SRC_J:           pc_d = j_target;
      SRC_JR, SRC_RET: pc_d = {jr_raw[XLEN-1:2], 2'b00};
      default:         pc_d = pc_plus4;
    endcase
    redirect_d = (src != SRC_SEQ);
    misalign_d = bus.jump_reg && (jr_raw[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (bus.stall) begin
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.redirect  = redirect_q;
  assign bus.misalign  = misalign_q;
  assign bus.ras_count = ras_count;
  assign bus.ras_empty = ras_empty;

endmodule
